fb_scanout: RTL and testbench

Frame-buffer scan-out engine sitting directly downstream of the map-fill stage: once the 320x240, 24-bit frame buffer has been populated, it reads the buffer on a dedicated synchronous read port and pushes pixels into the display FIFO. It upscales 2x in both directions, writing every source pixel twice per line and reading every source row twice, so the FIFO receives a 640x480 stream per frame. Output is flow-controlled by the FIFO's almost-full flag.

---
 rtl/fb_scanout.sv | 137 +++++++++++++
 tb/tb_fb_scanout.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: reads a SRC_W x SRC_H frame buffer and streams it into the
// display FIFO upscaled 2x in both directions, throttled by fifo_afull.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   frame_start      one-cycle request to scan a frame (ignored while busy)
//   fb_rd_addr/en    frame-buffer read port request
//   fb_rd_data       read data, valid the cycle after fb_rd_en
//   fifo_afull       display FIFO has fewer than two free entries
//   fifo_we/data     display FIFO write port
//   busy             engine is scanning a frame
//   frame_done       one-cycle pulse on the first idle cycle after a frame
module fb_scanout #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] fb_rd_addr,
    output logic              fb_rd_en,
    input  logic [DATA_W-1:0] fb_rd_data,
    input  logic              fifo_afull,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(SRC_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WR0,
        WR1
    } state_t;

    state_t              state_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic                dup_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic [DATA_W-1:0]   pix_q;
    logic                done_q;

    logic x_last;
    logic frame_last;

    assign x_last     = (x_q == X_LAST);
    // Last pixel of the second pass over the last source row.
    assign frame_last = x_last && dup_q && (y_q == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            dup_q      <= 1'b0;
            row_base_q <= '0;
            pix_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q    <= READ;
                        x_q        <= '0;
                        y_q        <= '0;
                        dup_q      <= 1'b0;
                        row_base_q <= '0;
                    end
                end
                READ: begin
                    if (!fifo_afull) begin
                        state_q <= WR0;
                    end
                end
                WR0: begin
                    pix_q   <= fb_rd_data;
                    state_q <= WR1;
                end
                WR1: begin
                    if (!x_last) begin
                        x_q <= x_q + 1'b1;
                    end else begin
                        x_q <= '0;
                        // Each source row is read twice before moving on.
                        if (!dup_q) begin
                            dup_q <= 1'b1;
                        end else begin
                            dup_q      <= 1'b0;
                            y_q        <= y_q + 1'b1;
                            row_base_q <= row_base_q + ROW_STEP;
                        end
                    end
                    if (frame_last) begin
                        state_q    <= IDLE;
                        x_q        <= '0;
                        y_q        <= '0;
                        dup_q      <= 1'b0;
                        row_base_q <= '0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q <= READ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign fb_rd_addr = row_base_q + {{(ADDR_W-XW){1'b0}}, x_q};
    assign fb_rd_en   = (state_q == READ) && !fifo_afull;
    assign fifo_we    = (state_q == WR0) || (state_q == WR1);

    // First write forwards the read data directly; the second replays it.
    always_comb begin
        fifo_data = '0;
        unique case (state_q)
            WR0:     fifo_data = fb_rd_data;
            WR1:     fifo_data = pix_q;
            default: fifo_data = '0;
        endcase
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced 32x16 source frame: randomized FIFO
// backpressure against a queue-based reference of the upscaled stream.
module tb_fb_scanout;

    localparam int W  = 32;
    localparam int H  = 16;
    localparam int AW = 17;
    localparam int DW = 24;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic [AW-1:0] fb_rd_addr;
    logic          fb_rd_en;
    logic [DW-1:0] fb_rd_data;
    logic          fifo_afull;
    logic          fifo_we;
    logic [DW-1:0] fifo_data;
    logic          busy;
    logic          frame_done;

    logic manual;
    logic afull_man;
    logic afull_rnd;

    int n_chk;
    int n_pass;
    int n_printed;

    fb_scanout #(
        .SRC_W (W),
        .SRC_H (H),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .fb_rd_addr (fb_rd_addr),
        .fb_rd_en   (fb_rd_en),
        .fb_rd_data (fb_rd_data),
        .fifo_afull (fifo_afull),
        .fifo_we    (fifo_we),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_afull = manual ? afull_man : afull_rnd;

    // Frame buffer holds data == address; data is garbage unless read.
    always @(posedge clk) begin
        if (fb_rd_en)
            fb_rd_data <= DW'(fb_rd_addr);
        else
            fb_rd_data <= DW'($urandom);
    end

    initial begin
        afull_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            afull_rnd = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else if (n_printed < 40) begin
            n_printed++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the whole frame as queues of addresses and pixels.
    int rd_q[$];
    int wr_q[$];
    int m_busy;
    int m_owed;
    int m_done;
    int stall_cnt;
    int busy_cnt;
    int wr_idx;
    int done_cnt;

    task automatic build_frame();
        rd_q.delete();
        wr_q.delete();
        for (int y = 0; y < H; y++)
            for (int d = 0; d < 2; d++)
                for (int x = 0; x < W; x++) begin
                    rd_q.push_back(y * W + x);
                    wr_q.push_back(y * W + x);
                    wr_q.push_back(y * W + x);
                end
    endtask

    initial begin
        m_busy = 0; m_owed = 0; m_done = 0;
        stall_cnt = 0; busy_cnt = 0; wr_idx = 0; done_cnt = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_we", 32'(fifo_we), 0);
            chk("rst_rd_en", 32'(fb_rd_en), 0);
            chk("rst_addr", 32'(fb_rd_addr), 0);
            chk("rst_data", 32'(fifo_data), 0);
            chk("rst_done", 32'(frame_done), 0);
            m_busy = 0; m_owed = 0; m_done = 0;
            rd_q.delete(); wr_q.delete();
            wr_idx = 0; busy_cnt = 0; stall_cnt = 0;
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("fifo_we", 32'(fifo_we), 32'(m_owed > 0));
            chk("fb_rd_en", 32'(fb_rd_en),
                32'(m_busy != 0 && m_owed == 0 && !fifo_afull));
            if (m_busy != 0 && m_owed == 0 && rd_q.size() > 0)
                chk("fb_rd_addr", 32'(fb_rd_addr), rd_q[0]);
            if (m_owed > 0 && wr_q.size() > 0)
                chk("fifo_data", 32'(fifo_data), wr_q[0]);
            if (fifo_we) begin
                if (wr_idx < 2)
                    chk("lit_first", 32'(fifo_data), 0);
                else if (wr_idx < 4)
                    chk("lit_second", 32'(fifo_data), 1);
                else if (wr_idx == 2 * W - 1)
                    chk("lit_row_end", 32'(fifo_data), W - 1);
                else if (wr_idx == 2 * W)
                    chk("lit_reread", 32'(fifo_data), 0);
                else if (wr_idx == 4 * W)
                    chk("lit_row1", 32'(fifo_data), W);
                else if (wr_idx >= 4 * W * H - 2)
                    chk("lit_last", 32'(fifo_data), W * H - 1);
                wr_idx++;
            end
            if (busy) busy_cnt++;
            if (frame_done) done_cnt++;

            m_done = 0;
            if (m_busy == 0) begin
                if (frame_start) begin
                    m_busy = 1;
                    build_frame();
                    wr_idx = 0; busy_cnt = 0; stall_cnt = 0;
                end
            end else if (m_owed > 0) begin
                void'(wr_q.pop_front());
                m_owed--;
                if (m_owed == 0 && wr_q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    chk("frame_writes", wr_idx, 4 * W * H);
                    chk("busy_cycles", busy_cnt, 6 * W * H + stall_cnt);
                end
            end else if (!fifo_afull) begin
                void'(rd_q.pop_front());
                m_owed = 2;
            end else begin
                stall_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!frame_done && n < lim) begin
            tick();
            n++;
        end
        n_chk++;
        if (frame_done) n_pass++;
        else $display("FAIL frame_done_timeout: got 0 expected 1");
    endtask

    task automatic wait_widx(input int target, input int lim);
        int n;
        n = 0;
        while (wr_idx < target && n < lim) begin
            tick();
            n++;
        end
        n_chk++;
        if (wr_idx >= target) n_pass++;
        else $display("FAIL write_wait_timeout: got %0d expected %0d",
                      wr_idx, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_chk = 0; n_pass = 0; n_printed = 0;
        rst = 1'b1; frame_start = 1'b0;
        manual = 1'b1; afull_man = 1'b0;

        // frame_start while in reset must be ignored
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_after_rst", 32'(busy), 0);

        // Frame 1: no backpressure, spurious frame_start mid-frame
        pulse_start();
        chk("lat_busy", 32'(busy), 1);
        chk("lat_no_we", 32'(fifo_we), 0);
        chk("lat_addr0", 32'(fb_rd_addr), 0);
        tick();
        chk("lat_first_we", 32'(fifo_we), 1);
        chk("lat_first_data", 32'(fifo_data), 0);
        wait_widx(200, 5000);
        pulse_start();
        wait_done(10000);
        repeat (3) tick();

        // Frame 2: hold afull for 10 cycles in READ at x=5
        pulse_start();
        n = 0;
        while (!(busy && !fifo_we && fb_rd_addr == 5) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_x5", 32'(fb_rd_addr), 5);
        afull_man = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk("stall_rd_en", 32'(fb_rd_en), 0);
            chk("stall_addr", 32'(fb_rd_addr), 5);
            chk("stall_we", 32'(fifo_we), 0);
            tick();
        end
        afull_man = 1'b0;
        #1;
        chk("resume_rd_en", 32'(fb_rd_en), 1);
        tick();
        // afull rising during WR0: both writes still happen
        afull_man = 1'b1;
        #3;
        chk("wr0_we", 32'(fifo_we), 1);
        chk("wr0_data", 32'(fifo_data), 5);
        tick();
        chk("wr1_we", 32'(fifo_we), 1);
        chk("wr1_data", 32'(fifo_data), 5);
        tick();
        chk("post_pair_we", 32'(fifo_we), 0);
        chk("post_pair_rd_en", 32'(fb_rd_en), 0);
        tick();
        manual = 1'b0;
        wait_done(20000);
        repeat (3) tick();

        // Frame 3: random backpressure, reset after write 1000
        pulse_start();
        n = 0;
        while (wr_idx != 1000 && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_w1000", wr_idx, 1000);
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(fifo_we), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rd_en", 32'(fb_rd_en), 0);
        chk("arst_data", 32'(fifo_data), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Frame 4: restarts from address 0 under random backpressure
        pulse_start();
        chk("restart_addr", 32'(fb_rd_addr), 0);
        chk("restart_busy", 32'(busy), 1);
        wait_done(20000);
        repeat (3) tick();

        chk("done_pulses", done_cnt, 3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
